// File: rtl/vga_wr_sched_if.sv
// vga_wr_sched_if: CPU store / character RAM write bundle for vga_wr_sched.
//   addr, datain, en : CPU store request (datain[7:0] carries the character)
//   vga_busy         : VGA scan owns the character RAM port this cycle
//   vga_we/waddr/wdata : character RAM write port
//   stall            : CPU must hold its store this cycle
//   fifo_level       : write-FIFO occupancy
//   clr_active       : screen clear in progress
// master = CPU/VGA side (testbench), slave = scheduler.
interface vga_wr_sched_if;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        en;
    logic        vga_busy;
    logic        vga_we;
    logic [11:0] vga_waddr;
    logic [7:0]  vga_wdata;
    logic        stall;
    logic [3:0]  fifo_level;
    logic        clr_active;

    modport master (
        output addr, datain, en, vga_busy,
        input  vga_we, vga_waddr, vga_wdata, stall, fifo_level, clr_active
    );

    modport slave (
        input  addr, datain, en, vga_busy,
        output vga_we, vga_waddr, vga_wdata, stall, fifo_level, clr_active
    );
endinterface

// File: rtl/vga_wr_sched.sv
// vga_wr_sched: buffers CPU stores aimed at the VGA character window in a
// small FIFO and retires them into the character RAM whenever the scan is
// not using the port. A store with addr[12] set is a clear command that
// fills the whole screen with CLR_CHAR, in program order with other stores.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : vga_wr_sched_if.slave (store request, RAM write port, status)
module vga_wr_sched #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned CHARS    = 2400,
    parameter logic [7:0]  CLR_CHAR = 8'h20,
    parameter logic [11:0] BASE     = 12'h002
) (
    input logic           clk,
    input logic           rst_n,
    vga_wr_sched_if.slave bus
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned CW = (CHARS > 1) ? $clog2(CHARS) : 1;

    typedef struct packed {
        logic        clr;
        logic [11:0] waddr;
        logic [7:0]  wdata;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [LW-1:0]   level_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    state_t          state_q;
    state_t          state_d;

    logic            hit;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            we_raw;
    logic            enter_clr;
    logic            exit_clr;
    logic [11:0]     waddr_c;
    logic [7:0]      wdata_c;
    entry_t          head;
    entry_t          new_entry;

    // Upper data bits and the address gap between clr and BASE are don't-care.
    logic            unused_bits;
    assign unused_bits = ^{bus.datain[31:8], bus.addr[19:13]};

    // Request decode and FIFO status.
    always_comb begin
        hit       = bus.en && (bus.addr[31:20] == BASE);
        full      = (level_q == LW'(DEPTH));
        empty     = (level_q == '0);
        push      = rst_n && hit && !full;
        head      = mem_q[rd_ptr_q];
        new_entry = '{clr: bus.addr[12], waddr: bus.addr[11:0], wdata: bus.datain[7:0]};
    end

    // Write-port scheduling and next-state logic.
    always_comb begin
        pop       = 1'b0;
        we_raw    = 1'b0;
        enter_clr = 1'b0;
        exit_clr  = 1'b0;
        waddr_c   = head.waddr;
        wdata_c   = head.wdata;
        cnt_d     = cnt_q;

        case (state_q)
            CLEAR: begin
                we_raw  = !bus.vga_busy;
                waddr_c = 12'(cnt_q);
                wdata_c = CLR_CHAR;
                if (we_raw) begin
                    if (cnt_q == CW'(CHARS - 1)) begin
                        exit_clr = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                if (!empty) begin
                    if (head.clr) begin
                        // Clear command is consumed without using the RAM port.
                        pop       = 1'b1;
                        enter_clr = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        we_raw = !bus.vga_busy;
                        pop    = we_raw;
                    end
                end
            end
        endcase

        level_d = level_q + LW'(push) - LW'(pop);

        if (enter_clr) begin
            state_d = CLEAR;
        end else if ((state_q == CLEAR) && !exit_clr) begin
            state_d = CLEAR;
        end else if (level_d != '0) begin
            state_d = DRAIN;
        end else begin
            state_d = IDLE;
        end
    end

    // Control state; reset discards all queued entries and any clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            level_q <= level_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    // Outputs are forced quiet while reset is held.
    assign bus.vga_we     = we_raw && rst_n;
    assign bus.vga_waddr  = waddr_c;
    assign bus.vga_wdata  = wdata_c;
    assign bus.stall      = hit && full && rst_n;
    assign bus.fifo_level = 4'(level_q);
    assign bus.clr_active = (state_q == CLEAR) && rst_n;

endmodule

// File: tb/tb_vga_wr_sched.sv
// tb_vga_wr_sched: randomized self-checking bench for vga_wr_sched. The
// reference model is the program-order stream of RAM writes implied by the
// accepted stores (a clear expands into CHARS fill writes).
module tb_vga_wr_sched;

    localparam int unsigned CHARS = 2400;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    vga_wr_sched_if bus ();

    vga_wr_sched #(
        .DEPTH    (8),
        .CHARS    (CHARS),
        .CLR_CHAR (8'h20),
        .BASE     (12'h002)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [20:0] exp_q [$];   // {from_clear, waddr, wdata}
    int   wr_count  = 0;
    int   busy_mode = 0;      // 0 never, 1 random, 2 toggle, 3 always
    int   busy_tog  = 0;
    logic last_stall;
    logic [11:0] last_waddr = 12'hfff;
    logic [7:0]  last_wdata = 8'h00;
    logic        last_from_clr = 1'b0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // One clock cycle: drive vga_busy, observe outputs, advance to next negedge.
    task automatic cycle();
        logic [20:0] e;
        case (busy_mode)
            0:       bus.vga_busy = 1'b0;
            1:       bus.vga_busy = 1'($urandom_range(0, 1));
            2: begin
                bus.vga_busy = busy_tog[0];
                busy_tog++;
            end
            default: bus.vga_busy = 1'b1;
        endcase
        #1;
        last_stall = bus.stall;
        if (!rst_n) begin
            checks++;
            if (bus.vga_we !== 1'b0 || bus.stall !== 1'b0 || bus.clr_active !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet: we=%b stall=%b clr_active=%b, expected 0 0 0",
                         bus.vga_we, bus.stall, bus.clr_active);
            end
        end else if (bus.vga_we === 1'b1) begin
            wr_count++;
            checks++;
            if (bus.vga_busy) begin
                errors++;
                $display("FAIL we_while_busy: vga_we=1 with vga_busy=1, expected vga_we=0");
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h, expected no write",
                         bus.vga_waddr, bus.vga_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus.clr_active, bus.vga_waddr, bus.vga_wdata} !== e) begin
                    errors++;
                    $display("FAIL write_order: clr=%b addr=%h data=%h, expected clr=%b addr=%h data=%h",
                             bus.clr_active, bus.vga_waddr, bus.vga_wdata, e[20], e[19:8], e[7:0]);
                end
            end
            last_waddr    = bus.vga_waddr;
            last_wdata    = bus.vga_wdata;
            last_from_clr = bus.clr_active;
        end else if (bus.vga_we !== 1'b0) begin
            errors++;
            checks++;
            $display("FAIL we_unknown: vga_we=%b, expected 0 or 1", bus.vga_we);
        end
        @(negedge clk);
    endtask

    // Expected writes implied by one accepted store.
    task automatic expect_store(input logic [31:0] a, input logic [7:0] d);
        if (a[31:20] == 12'h002) begin
            if (a[12]) begin
                for (int i = 0; i < int'(CHARS); i++) begin
                    exp_q.push_back({1'b1, 12'(i), 8'h20});
                end
            end else begin
                exp_q.push_back({1'b0, a[11:0], d});
            end
        end
    endtask

    // Present a store and hold it while stalled.
    task automatic store(input logic [31:0] a, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        bus.en     = 1'b1;
        bus.addr   = a;
        bus.datain = {24'($urandom), d};
        for (int i = 0; i < 6000; i++) begin
            cycle();
            if (!last_stall) begin
                ok = 1'b1;
                break;
            end
        end
        bus.en = 1'b0;
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL store_timeout: addr=%h still stalled, expected acceptance", a);
        end else begin
            expect_store(a, d);
        end
    endtask

    // Run until every expected write has been seen, then confirm quiescence.
    task automatic wait_drain(input int budget, input string name);
        bus.en = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            cycle();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d writes outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) cycle();
        checks++;
        if (bus.fifo_level !== 4'd0 || bus.clr_active !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: fifo_level=%0d clr_active=%b, expected 0 0",
                     name, bus.fifo_level, bus.clr_active);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        busy_mode  = 0;
        bus.en     = 1'b1;
        bus.addr   = 32'h0020_0001;
        bus.datain = 32'h0000_0033;
        repeat (3) cycle();
        bus.en = 1'b0;
        rst_n  = 1'b1;
        #1;
        checks++;
        if (bus.fifo_level !== 4'd0 || bus.vga_we !== 1'b0 || bus.stall !== 1'b0 ||
            bus.clr_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: level=%0d we=%b stall=%b clr=%b, expected 0 0 0 0",
                     bus.fifo_level, bus.vga_we, bus.stall, bus.clr_active);
        end
        repeat (3) cycle();
    endtask

    task automatic test_single();
        int n0;
        busy_mode = 0;
        store(32'h0020_0005, 8'h41);
        n0 = wr_count;
        cycle();
        checks++;
        if (wr_count != n0 + 1 || last_waddr !== 12'h005 || last_wdata !== 8'h41) begin
            errors++;
            $display("FAIL single_latency: writes=%0d addr=%h data=%h, expected 1 005 41",
                     wr_count - n0, last_waddr, last_wdata);
        end
        checks++;
        if (bus.fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL single_level: fifo_level=%0d, expected 0", bus.fifo_level);
        end
    endtask

    task automatic test_miss();
        busy_mode = 0;
        store(32'h0010_0000, 8'h77);
        checks++;
        if (last_stall !== 1'b0) begin
            errors++;
            $display("FAIL miss_stall: stall=%b, expected 0", last_stall);
        end
        repeat (4) cycle();
        checks++;
        if (bus.fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL miss_level: fifo_level=%0d, expected 0", bus.fifo_level);
        end
    endtask

    task automatic test_full();
        busy_mode = 3;
        for (int i = 0; i < 8; i++) begin
            store(32'h0020_0100 + 32'(i), 8'h30 + 8'(i));
        end
        checks++;
        if (bus.fifo_level !== 4'd8) begin
            errors++;
            $display("FAIL full_level: fifo_level=%0d, expected 8", bus.fifo_level);
        end
        bus.en     = 1'b1;
        bus.addr   = 32'h0020_0108;
        bus.datain = 32'h0000_0038;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (last_stall !== 1'b1) begin
                errors++;
                $display("FAIL full_stall: stall=%b on cycle %0d, expected 1", last_stall, i);
            end
        end
        busy_mode = 0;
        store(32'h0020_0108, 8'h38);
        wait_drain(100, "full");
    endtask

    task automatic test_clear_seq();
        busy_mode = 0;
        store(32'h0020_0010, 8'h58);
        store(32'h0020_1000, 8'h00);
        store(32'h0020_0010, 8'h59);
        wait_drain(6000, "clear_seq");
    endtask

    task automatic test_clear_toggle();
        int n0;
        busy_mode = 2;
        busy_tog  = 0;
        n0 = wr_count;
        store(32'h0020_1000, 8'h00);
        wait_drain(6000, "clear_toggle");
        checks++;
        if (wr_count - n0 != int'(CHARS)) begin
            errors++;
            $display("FAIL clear_toggle_count: writes=%0d, expected %0d", wr_count - n0, CHARS);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [11:0] top;
        busy_mode = 1;
        for (int i = 0; i < 80; i++) begin
            if (i == 40) begin
                store(32'h0020_1000 | 32'(12'($urandom)), 8'($urandom));
            end else begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: begin
                        a = {12'h002, 7'($urandom), 1'b0, 12'($urandom)};
                        store(a, 8'($urandom));
                    end
                    6, 7: begin
                        top = 12'($urandom);
                        if (top == 12'h002) top = 12'h003;
                        store({top, 20'($urandom)}, 8'($urandom));
                    end
                    default: begin
                        bus.en = 1'b0;
                        cycle();
                    end
                endcase
            end
        end
        wait_drain(8000, "random");
    endtask

    task automatic test_reset_mid_clear();
        int n0;
        bit hit100;
        busy_mode = 0;
        hit100 = 1'b0;
        store(32'h0020_1000, 8'h00);
        store(32'h0020_0200, 8'h61);
        store(32'h0020_0201, 8'h62);
        store(32'h0020_0202, 8'h63);
        for (int i = 0; i < 300; i++) begin
            if (last_from_clr && last_waddr == 12'd99) begin
                hit100 = 1'b1;
                break;
            end
            cycle();
        end
        checks++;
        if (!hit100 || bus.fifo_level !== 4'd3) begin
            errors++;
            $display("FAIL midclr_setup: reached=%b fifo_level=%0d, expected 1 3",
                     hit100, bus.fifo_level);
        end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if (bus.vga_we !== 1'b0 || bus.fifo_level !== 4'd0 || bus.clr_active !== 1'b0) begin
            errors++;
            $display("FAIL midclr_abort: we=%b level=%0d clr=%b, expected 0 0 0",
                     bus.vga_we, bus.fifo_level, bus.clr_active);
        end
        n0 = wr_count;
        repeat (20) cycle();
        checks++;
        if (wr_count != n0) begin
            errors++;
            $display("FAIL midclr_silent: writes=%0d after reset, expected 0", wr_count - n0);
        end
        store(32'h0020_0300, 8'h5a);
        wait_drain(50, "midclr_resume");
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.addr     = '0;
        bus.datain   = '0;
        bus.vga_busy = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_miss();
        test_full();
        test_clear_seq();
        test_clear_toggle();
        test_random();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_wr_sched.md
VGA_WR_SCHED -- requirements
Module: vga_wr_sched

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DEPTH, 8, write-FIFO entries (power of 2).
- CHARS, 2400, character cells cleared by a clear command.
- CLR_CHAR, 8'h20, fill byte used by clear.
- BASE, 12'h002, addr[31:20] value selecting the VGA window.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all state changes on its rising edge.
- rst_n, in, 1, synchronous active-low reset.
- addr, in, 32, CPU store address.
- datain, in, 32, CPU store data; only [7:0] is used.
- en, in, 1, CPU store strobe.
- vga_busy, in, 1, VGA scan owns the character RAM port this cycle.
- vga_we, out, 1, character RAM write enable.
- vga_waddr, out, 12, character RAM write address.
- vga_wdata, out, 8, character RAM write data.
- stall, out, 1, CPU must hold its store (en, addr, datain) this cycle.
- fifo_level, out, 4, current FIFO occupancy, 0..DEPTH.
- clr_active, out, 1, a screen clear is in progress.

REQ-003 Only one clock exists; reset is synchronous and active-low on rst_n.

Function
REQ-004 hit = en & (addr[31:20]==BASE); stores with hit=0 are ignored entirely.
REQ-005 FIFO entry = {clr=addr[12], waddr=addr[11:0], wdata=datain[7:0]}, 21 bits.
REQ-006 Enqueue on a clock edge when hit & ~full; full is registered occupancy==DEPTH.
REQ-007 stall = hit & full, combinational; a same-cycle pop does not relieve it (no enqueue-on-full).
REQ-008 FSM states: IDLE (FIFO empty, no clear), DRAIN (FIFO non-empty), CLEAR.
REQ-009 In IDLE/DRAIN with head.clr=0: vga_we = ~empty & ~vga_busy; vga_waddr/vga_wdata = head fields, combinational; pop on the same edge that vga_we=1.
REQ-010 In IDLE/DRAIN with head.clr=1: pop the entry regardless of vga_busy, vga_we=0 that cycle, clear counter <= 0, next state = CLEAR.
REQ-011 In CLEAR: vga_we = ~vga_busy, vga_waddr = counter, vga_wdata = CLR_CHAR; counter increments only when vga_we=1.
REQ-012 Exit CLEAR after the write at counter==CHARS-1: next state is DRAIN if FIFO non-empty, else IDLE.
REQ-013 During CLEAR, the FIFO keeps accepting stores but is not popped; program order is preserved.
REQ-014 Latency: a store accepted at edge t into an empty FIFO with vga_busy=0 drives vga_we=1 throughout cycle t+1.
REQ-015 Simultaneous enqueue and pop leaves fifo_level unchanged; read and write pointers wrap modulo DEPTH.
REQ-016 clr_active = (state==CLEAR); vga_we is never asserted while vga_busy=1.
REQ-017 At most one character RAM write occurs per cycle.

Reset
REQ-018 When rst_n=0 at an edge: pointers <= 0, fifo_level <= 0, state <= IDLE, counter <= 0.
REQ-019 During and after reset, vga_we=0, stall=0 and clr_active=0.
REQ-020 Reset mid-CLEAR or with entries queued aborts immediately and discards all entries; no further writes are issued.

Verification
REQ-021 Store addr=0x0020_0005, datain=0x41 with vga_busy=0 -> next cycle vga_we=1, vga_waddr=0x005, vga_wdata=0x41; fifo_level returns to 0.
REQ-022 vga_busy=1 held while 9 consecutive VGA stores are presented -> fifo_level reaches 8, the 9th store sees stall=1 until vga_busy falls; all 9 are written in order.
REQ-023 Store addr=0x0010_0000 (dmem window) -> no enqueue, stall=0, vga_we stays 0.
REQ-024 Sequence: store 0x0020_0010/0x58, then clear (0x0020_1000), then 0x0020_0010/0x59 -> 0x58 is written, then 2400 writes of 0x20 to addresses 0..2399, then 0x59 to 0x010; clr_active is high only across the clear.
REQ-025 Clear with vga_busy toggling every other cycle -> exactly 2400 writes, with no address skipped or repeated.
REQ-026 rst_n=0 asserted at clear counter=100 with 3 entries queued -> next cycle vga_we=0, fifo_level=0, clr_active=0, and no writes until a new store is accepted.
